if_fetch: RTL and testbench

- Instruction-fetch stage of the pipeline, directly upstream of the decode stage.
- Keeps the PC and reads each 32-bit instruction from the shared byte-wide memory controller, one byte per handshake, little-endian.
- Presents {pc_o, inst_o, inst_valid_o} to the decode stage.
- Honours pipeline stall and branch/jump redirect. A redirect discards any partially fetched instruction.

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/if_icache.sv | 52 +++++
 rtl/if_fetch.sv | 161 ++++++++++++++++
 tb/tb_if_fetch.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage (bus widths, NOP, reset level,
// fetch state encoding).
package if_fetch_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstW     = 32;

  localparam logic [InstAddrW-1:0] ZeroWord  = 32'h0000_0000;
  localparam logic [InstW-1:0]     NopInst   = 32'h0000_0013;
  localparam logic                 RstEnable = 1'b0;

  typedef enum logic {
    StFetch,
    StPresent
  } fetch_state_e;

endpackage

// File: rtl/if_icache.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, single fill port.
// Only instantiated when ICACHE_EN is defined.
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int unsigned IDX_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:2]       lookup_addr_i,
  output logic              hit_o,
  output logic [InstW-1:0]  rdata_o,
  input  logic              fill_i,
  input  logic [31:2]       fill_addr_i,
  input  logic [InstW-1:0]  fill_data_i
);

  localparam int unsigned Lines = 1 << IDX_W;
  localparam int unsigned TagW  = 30 - IDX_W;

  logic [Lines-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [InstW-1:0] data_q [Lines];

  logic [IDX_W-1:0] lookup_idx;
  logic [TagW-1:0]  lookup_tag;
  logic [IDX_W-1:0] fill_idx;

  assign lookup_idx = lookup_addr_i[IDX_W+1:2];
  assign lookup_tag = lookup_addr_i[31:IDX_W+2];
  assign fill_idx   = fill_addr_i[IDX_W+1:2];

  assign hit_o   = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign rdata_o = data_q[lookup_idx];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid_q <= '0;
    end else if (fill_i) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[fill_idx]  <= fill_addr_i[31:IDX_W+2];
      data_q[fill_idx] <= fill_data_i;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles 32-bit little-endian words from a byte-wide memory port.
// Define ICACHE_EN to add a direct-mapped instruction cache in front of the memory fetch.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NopInst
`ifdef ICACHE_EN
  , parameter int unsigned ICACHE_IDX_W = 7
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 jump_i,
  input  logic [InstAddrW-1:0] jump_addr_i,
  output logic                 mem_req_o,
  output logic [InstAddrW-1:0] mem_addr_o,
  input  logic [7:0]           mem_rdata_i,
  input  logic                 mem_rvalid_i,
  output logic [InstAddrW-1:0] pc_o,
  output logic [InstW-1:0]     inst_o,
  output logic                 inst_valid_o
);

  fetch_state_e         state_q, state_d;
  logic [InstAddrW-1:0] pc_q, pc_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [23:0]          buf_q, buf_d;
  logic                 req_q, req_d;
  logic [InstAddrW-1:0] addr_q, addr_d;
  logic [InstAddrW-1:0] pc_out_q, pc_out_d;
  logic [InstW-1:0]     inst_q, inst_d;
  logic                 valid_q, valid_d;

  logic                 cache_hit;
  logic [InstW-1:0]     cache_word;

`ifdef ICACHE_EN
  // With a cache, entering FETCH spends one cycle on lookup before any memory request.
  localparam logic IssueOnEntry = 1'b0;
  logic fill_en;

  assign fill_en = (state_q == StFetch) && req_q && mem_rvalid_i && (cnt_q == 2'd3) && !jump_i;

  if_icache #(
    .IDX_W(ICACHE_IDX_W)
  ) u_icache (
    .clk          (clk),
    .rst          (rst),
    .lookup_addr_i(pc_q[31:2]),
    .hit_o        (cache_hit),
    .rdata_o      (cache_word),
    .fill_i       (fill_en),
    .fill_addr_i  (pc_q[31:2]),
    .fill_data_i  ({mem_rdata_i, buf_q})
  );
`else
  localparam logic IssueOnEntry = 1'b1;
  assign cache_hit  = 1'b0;
  assign cache_word = ZeroWord;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    req_d    = req_q;
    addr_d   = addr_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    valid_d  = valid_q;

    if (jump_i) begin
      pc_d    = jump_addr_i & ~32'd3;
      cnt_d   = 2'd0;
      state_d = StFetch;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      req_d   = IssueOnEntry;
      addr_d  = jump_addr_i & ~32'd3;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (!req_q) begin
            // Idle FETCH cycle: after reset, or the cache lookup slot.
            if (cache_hit) begin
              state_d  = StPresent;
              inst_d   = cache_word;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
            end else begin
              req_d  = 1'b1;
              addr_d = pc_q;
            end
          end else if (mem_rvalid_i) begin
            if (cnt_q == 2'd3) begin
              state_d  = StPresent;
              inst_d   = {mem_rdata_i, buf_q};
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              req_d    = 1'b0;
            end else begin
              case (cnt_q)
                2'd0:    buf_d[7:0]   = mem_rdata_i;
                2'd1:    buf_d[15:8]  = mem_rdata_i;
                default: buf_d[23:16] = mem_rdata_i;
              endcase
              cnt_d  = cnt_q + 2'd1;
              addr_d = pc_q + {30'b0, cnt_q} + 32'd1;
            end
          end
        end
        StPresent: begin
          if (!stall_i) begin
            pc_d    = pc_q + 32'd4;
            cnt_d   = 2'd0;
            state_d = StFetch;
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            req_d   = IssueOnEntry;
            addr_d  = pc_q + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      cnt_q    <= 2'd0;
      buf_q    <= '0;
      req_q    <= 1'b0;
      addr_q   <= ZeroWord;
      pc_out_q <= ZeroWord;
      inst_q   <= NOP_INST;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
    end
  end

  assign mem_req_o    = req_q;
  assign mem_addr_o   = addr_q;
  assign pc_o         = pc_out_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus a randomized run checked against a
// transaction-level model (expected PC stream and little-endian words from the memory image).
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;

  logic [7:0]  mem [1024];
  int errors = 0;
  int checks = 0;
  int rv_mode = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:0]];

  if_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall),
    .jump_i      (jump),
    .jump_addr_i (jump_addr),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata),
    .mem_rvalid_i(mem_rvalid),
    .pc_o        (pc),
    .inst_o      (inst),
    .inst_valid_o(inst_valid)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [9:0] b;
    b = a[9:0];
    return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
  endfunction

  // Advance one edge, sample-safe point is #1 after it; rvalid for the next edge set here.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (rv_mode)
      0:       mem_rvalid = 1'b1;
      1:       mem_rvalid = ($urandom_range(0, 1) == 1);
      2:       mem_rvalid = (cyc % 3 == 0);
      default: mem_rvalid = 1'b1;
    endcase
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bit ok;
    rv_mode = 0;
    stall = 1'b0;
    jump = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (inst !== 32'h13) begin errors++; $display("FAIL reset_inst got %h want 00000013", inst); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'(i)) begin
        errors++;
        $display("FAIL first_fetch_addr got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, i);
      end
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h13 || pc !== 32'h0) begin
      errors++;
      $display("FAIL first_inst got v=%b inst=%h pc=%h want v=1 inst=00000013 pc=0",
               inst_valid, inst, pc);
    end
    wait_req(10, ok);
    checks++;
    if (!ok || mem_addr !== 32'h4) begin
      errors++;
      $display("FAIL next_fetch got ok=%b addr=%h want ok=1 addr=4", ok, mem_addr);
    end
  endtask

  task automatic test_stall();
    bit ok;
    stall = 1'b1;
    wait_valid(40, ok);
    checks++;
    if (!ok || pc !== 32'h4 || inst !== word_at(32'h4)) begin
      errors++;
      $display("FAIL stall_pc4 got ok=%b pc=%h inst=%h want pc=4 inst=%h", ok, pc, inst, word_at(4));
    end
    stall = 1'b0;
    tick();
    stall = 1'b1;
    wait_valid(40, ok);
    checks++;
    if (!ok || pc !== 32'h8 || inst !== word_at(32'h8)) begin
      errors++;
      $display("FAIL stall_pc8 got ok=%b pc=%h inst=%h want pc=8 inst=%h", ok, pc, inst, word_at(8));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || pc !== 32'h8 || inst !== word_at(32'h8) || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold got v=%b pc=%h inst=%h req=%b want v=1 pc=8 inst=%h req=0",
                 inst_valid, pc, inst, mem_req, word_at(8));
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %b want 0", inst_valid); end
    wait_req(10, ok);
    checks++;
    if (!ok || mem_addr !== 32'hC) begin
      errors++;
      $display("FAIL stall_resume got ok=%b addr=%h want addr=c", ok, mem_addr);
    end
  endtask

  task automatic test_jump_mid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req && mem_addr == 32'hE) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL jump_setup got no addr 0000000e want seen"); end
    jump = 1'b1;
    jump_addr = 32'h102;
    tick();
    jump = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL jump_valid got %b want 0", inst_valid); end
    wait_req(10, ok);
    checks++;
    if (!ok || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL jump_addr got ok=%b addr=%h want addr=100", ok, mem_addr);
    end
    stall = 1'b1;
    wait_valid(40, ok);
    checks++;
    if (!ok || pc !== 32'h100 || inst !== word_at(32'h100)) begin
      errors++;
      $display("FAIL jump_inst got ok=%b pc=%h inst=%h want pc=100 inst=%h",
               ok, pc, inst, word_at(32'h100));
    end
  endtask

  task automatic test_jump_stall();
    bit ok;
    jump = 1'b1;
    jump_addr = 32'h200;
    tick();
    jump = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h13) begin
      errors++;
      $display("FAIL jump_over_stall got v=%b inst=%h want v=0 inst=00000013", inst_valid, inst);
    end
    wait_valid(40, ok);
    checks++;
    if (!ok || pc !== 32'h200 || inst !== word_at(32'h200)) begin
      errors++;
      $display("FAIL jump_stall_inst got ok=%b pc=%h inst=%h want pc=200 inst=%h",
               ok, pc, inst, word_at(32'h200));
    end
    stall = 1'b0;
    tick();
  endtask

  task automatic test_reset_midfetch();
    bit ok;
    rv_mode = 2;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (mem_req && mem_addr[1:0] == 2'd2) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL midfetch_setup got no byte2 request want seen"); end
    rst = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || pc !== 32'h0 || inst !== 32'h13 ||
        inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL midfetch_reset got req=%b addr=%h pc=%h inst=%h v=%b want 0/0/0/13/0",
               mem_req, mem_addr, pc, inst, inst_valid);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL midfetch_restart got req=%b addr=%h want req=1 addr=0", mem_req, mem_addr);
    end
    stall = 1'b1;
    wait_valid(60, ok);
    checks++;
    if (!ok || pc !== 32'h0 || inst !== 32'h13) begin
      errors++;
      $display("FAIL midfetch_inst got ok=%b pc=%h inst=%h want pc=0 inst=00000013", ok, pc, inst);
    end
    stall = 1'b0;
    tick();
  endtask

  // Transaction-level model: expected PC of the instruction being fetched/presented and how
  // many of its bytes have been accepted.
  task automatic test_random();
    logic [31:0] exp_pc;
    int nbytes;
    int presented;
    rv_mode = 1;
    stall = 1'b0;
    jump = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_pc = 32'h0;
    nbytes = 0;
    presented = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (mem_req) begin
        checks++;
        if (mem_addr !== exp_pc + 32'(nbytes)) begin
          errors++;
          $display("FAIL rand_addr cyc=%0d got %h want %h", cyc, mem_addr, exp_pc + 32'(nbytes));
        end
      end
      if (inst_valid) begin
        presented++;
        checks++;
        if (pc !== exp_pc || inst !== word_at(exp_pc) || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL rand_inst cyc=%0d got pc=%h inst=%h req=%b want pc=%h inst=%h req=0",
                   cyc, pc, inst, mem_req, exp_pc, word_at(exp_pc));
        end
      end
      stall = ($urandom_range(0, 9) < 3);
      jump = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 4) == 0) jump_addr = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else jump_addr = $urandom;
      if (jump) begin
        exp_pc = jump_addr & ~32'd3;
        nbytes = 0;
      end else if (inst_valid && !stall) begin
        exp_pc = exp_pc + 32'd4;
        nbytes = 0;
      end else if (mem_req && mem_rvalid) begin
        nbytes = (nbytes == 3) ? 0 : nbytes + 1;
      end
    end
    jump = 1'b0;
    stall = 1'b0;
    checks++;
    if (presented < 50) begin
      errors++;
      $display("FAIL rand_progress got %0d presentations want >=50", presented);
    end
  endtask

`ifdef ICACHE_EN
  task automatic test_icache();
    bit ok;
    int reqs;
    rv_mode = 0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    stall = 1'b1;
    wait_valid(40, ok);
    stall = 1'b0;
    tick();
    stall = 1'b1;
    wait_valid(40, ok);
    checks++;
    if (!ok || pc !== 32'h4) begin errors++; $display("FAIL icache_pass1 got pc=%h want 4", pc); end
    stall = 1'b0;
    jump = 1'b1;
    jump_addr = 32'h0;
    tick();
    jump = 1'b0;
    reqs = mem_req ? 1 : 0;
    tick();
    checks++;
    if (inst_valid !== 1'b1 || pc !== 32'h0 || inst !== word_at(32'h0)) begin
      errors++;
      $display("FAIL icache_hit0 got v=%b pc=%h inst=%h want v=1 pc=0", inst_valid, pc, inst);
    end
    reqs += mem_req ? 1 : 0;
    tick();
    reqs += mem_req ? 1 : 0;
    tick();
    reqs += mem_req ? 1 : 0;
    checks++;
    if (inst_valid !== 1'b1 || pc !== 32'h4 || inst !== word_at(32'h4)) begin
      errors++;
      $display("FAIL icache_hit4 got v=%b pc=%h inst=%h want v=1 pc=4", inst_valid, pc, inst);
    end
    checks++;
    if (reqs != 0) begin errors++; $display("FAIL icache_noreq got %0d requests want 0", reqs); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13;
    mem[1] = 8'h00;
    mem[2] = 8'h00;
    mem[3] = 8'h00;
    test_reset();
    test_stall();
    test_jump_mid();
    test_jump_stall();
    test_reset_midfetch();
    test_random();
`ifdef ICACHE_EN
    test_icache();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
